// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Datapath-to-controller bundle for the multicycle controller.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic       instr_done;
  logic       halted;

  // Datapath side: supplies instruction fields and flags, consumes strobes.
  modport master (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
    input  pc_src, alu_src_a, alu_src_b, alu_op, state, instr_done, halted
  );

  modport slave (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
    output pc_src, alu_src_a, alu_src_b, alu_op, state, instr_done, halted
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle RV32 core.
//            Define MULTICYCLE_ILLEGAL_HALT_EN to halt on unsupported opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multicycle_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_RSV6   = 3'd6,
    ST_RSV7   = 3'd7
  } state_t;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  state_t     r_state;
  logic [6:0] r_opcode;
  logic [2:0] r_funct3;

  logic w_legal;
  logic w_is_alu;
  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_unused;

  // Legality is judged on the live IR value; later states use the latched copy.
  assign w_legal = (bus.opcode == c_OP_R)     || (bus.opcode == c_OP_I)     ||
                   (bus.opcode == c_OP_LOAD)  || (bus.opcode == c_OP_STORE) ||
                   (bus.opcode == c_OP_BRANCH);

  assign w_is_alu    = (r_opcode == c_OP_R) || (r_opcode == c_OP_I);
  assign w_is_load   = (r_opcode == c_OP_LOAD);
  assign w_is_store  = (r_opcode == c_OP_STORE);
  assign w_is_branch = (r_opcode == c_OP_BRANCH);
  assign w_unused    = &{1'b0, r_funct3[2:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_opcode <= 7'd0;
      r_funct3 <= 3'd0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.mem_ready) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_opcode <= bus.opcode;
          r_funct3 <= bus.funct3;
          if (w_legal) begin
            r_state <= ST_EXEC;
          end else begin
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
            r_state <= ST_HALT;
`else
            r_state <= ST_FETCH;
`endif
          end
        end
        ST_EXEC: begin
          if (w_is_alu)                     r_state <= ST_WB;
          else if (w_is_load || w_is_store) r_state <= ST_MEM;
          else                              r_state <= ST_FETCH;
        end
        ST_MEM: begin
          if (bus.mem_ready) r_state <= w_is_load ? ST_WB : ST_FETCH;
        end
        ST_WB: r_state <= ST_FETCH;
        ST_HALT: begin
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
          r_state <= ST_HALT;
`else
          r_state <= ST_FETCH;
`endif
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_pc_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_instr_done;
  logic       w_halted;

  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_instr_done = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
      end
      ST_DECODE: begin
`ifndef MULTICYCLE_ILLEGAL_HALT_EN
        w_instr_done = ~w_legal;
`endif
      end
      ST_EXEC: begin
        if (w_is_alu) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = (r_opcode == c_OP_I) ? 2'b10 : 2'b00;
          w_alu_op    = 2'b10;
        end else if (w_is_load || w_is_store) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
        end else if (w_is_branch) begin
          // funct3[0] selects BNE, which inverts the sense of the zero flag.
          w_alu_src_a  = 1'b1;
          w_alu_op     = 2'b01;
          w_pc_src     = 1'b1;
          w_pc_write   = bus.zero ^ r_funct3[0];
          w_instr_done = 1'b1;
        end
      end
      ST_MEM: begin
        w_mem_read   = w_is_load;
        w_mem_write  = ~w_is_load;
        w_instr_done = ~w_is_load & bus.mem_ready;
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_is_load;
        w_instr_done = 1'b1;
      end
      ST_HALT: begin
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
        w_halted = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Reset forces every output low without waiting for a clock edge.
  assign bus.pc_write   = rst_n & w_pc_write;
  assign bus.ir_write   = rst_n & w_ir_write;
  assign bus.reg_write  = rst_n & w_reg_write;
  assign bus.mem_read   = rst_n & w_mem_read;
  assign bus.mem_write  = rst_n & w_mem_write;
  assign bus.mem_to_reg = rst_n & w_mem_to_reg;
  assign bus.pc_src     = rst_n & w_pc_src;
  assign bus.alu_src_a  = rst_n & w_alu_src_a;
  assign bus.alu_src_b  = {2{rst_n}} & w_alu_src_b;
  assign bus.alu_op     = {2{rst_n}} & w_alu_op;
  assign bus.state      = {3{rst_n}} & r_state;
  assign bus.instr_done = rst_n & w_instr_done;
  assign bus.halted     = rst_n & w_halted;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  // Field order: pcw irw rw mr mw m2r psrc asa asb[1:0] aop[1:0] st[2:0] done halt
  function automatic logic [16:0] mk(input bit pcw, input bit irw, input bit rw,
                                     input bit mr, input bit mw, input bit m2r,
                                     input bit psrc, input bit asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic [2:0] st, input bit done, input bit halt);
    return {pcw, irw, rw, mr, mw, m2r, psrc, asa, asb, aop, st, done, halt};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.state, bus.instr_done, bus.halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [16:0] exp);
    @(negedge clk);
    check(tag, {15'd0, obs()}, {15'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [16:0] v_f_rdy, v_f_wait, v_dec, v_ex_ls, v_wb_alu;

  task automatic run_branch(input string tag, input logic [2:0] f3, input bit z, input bit pcw);
    bus.opcode    = c_OP_BRANCH;
    bus.funct3    = f3;
    bus.zero      = z;
    bus.mem_ready = 1'b1;
    cyc({tag, "_fetch"}, v_f_rdy);
    cyc({tag, "_decode"}, v_dec);
    cyc({tag, "_exec"}, mk(pcw,0,0,0,0,0,1,1,2'b00,2'b01,3'd2,1,0));
  endtask

  initial begin
    v_f_rdy  = mk(1,1,0,1,0,0,0,0,2'b01,2'b00,3'd0,0,0);
    v_f_wait = mk(0,0,0,1,0,0,0,0,2'b01,2'b00,3'd0,0,0);
    v_dec    = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd1,0,0);
    v_ex_ls  = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'd2,0,0);
    v_wb_alu = mk(0,0,1,0,0,0,0,0,2'b00,2'b00,3'd4,1,0);

    bus.opcode    = c_OP_R;
    bus.funct3    = 3'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cyc("reset_outputs", 17'd0);
    rst_n = 1'b1;

    // R-type: 0,1,2,4 then back to 0
    cyc("r_fetch", v_f_rdy);
    cyc("r_decode", v_dec);
    cyc("r_exec", mk(0,0,0,0,0,0,0,1,2'b00,2'b10,3'd2,0,0));
    cyc("r_wb", v_wb_alu);

    bus.opcode = c_OP_I;
    cyc("i_fetch", v_f_rdy);
    cyc("i_decode", v_dec);
    cyc("i_exec", mk(0,0,0,0,0,0,0,1,2'b10,2'b10,3'd2,0,0));
    cyc("i_wb", v_wb_alu);

    // Load with two wait cycles in MEM
    bus.opcode = c_OP_LOAD;
    cyc("ld_fetch", v_f_rdy);
    cyc("ld_decode", v_dec);
    cyc("ld_exec", v_ex_ls);
    bus.mem_ready = 1'b0;
    cyc("ld_mem_wait1", mk(0,0,0,1,0,0,0,0,2'b00,2'b00,3'd3,0,0));
    cyc("ld_mem_wait2", mk(0,0,0,1,0,0,0,0,2'b00,2'b00,3'd3,0,0));
    bus.mem_ready = 1'b1;
    cyc("ld_mem_rdy", mk(0,0,0,1,0,0,0,0,2'b00,2'b00,3'd3,0,0));
    cyc("ld_wb", mk(0,0,1,0,0,1,0,0,2'b00,2'b00,3'd4,1,0));

    run_branch("beq_z1", 3'b000, 1'b1, 1'b1);
    run_branch("beq_z0", 3'b000, 1'b0, 1'b0);
    run_branch("bne_z1", 3'b001, 1'b1, 1'b0);
    run_branch("bne_z0", 3'b001, 1'b0, 1'b1);

    // Store with a stalled fetch
    bus.opcode    = c_OP_STORE;
    bus.mem_ready = 1'b0;
    cyc("st_fetch_wait1", v_f_wait);
    cyc("st_fetch_wait2", v_f_wait);
    bus.mem_ready = 1'b1;
    cyc("st_fetch_rdy", v_f_rdy);
    cyc("st_decode", v_dec);
    cyc("st_exec", v_ex_ls);
    cyc("st_mem", mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'd3,1,0));

    // Reset dropped while a store is waiting in MEM
    cyc("st2_fetch", v_f_rdy);
    cyc("st2_decode", v_dec);
    cyc("st2_exec", v_ex_ls);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("st2_mem_pending", {15'd0, obs()}, {15'd0, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'd3,0,0)});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem", {15'd0, obs()}, 32'd0);
    @(posedge clk);
    #1;
    cyc("rst_hold", 17'd0);
    rst_n         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = c_OP_R;
    cyc("restart_fetch", v_f_rdy);
    cyc("restart_decode", v_dec);
    cyc("restart_exec", mk(0,0,0,0,0,0,0,1,2'b00,2'b10,3'd2,0,0));
    cyc("restart_wb", v_wb_alu);

    // Unsupported opcode
    bus.opcode = 7'b1111111;
    cyc("ill_fetch", v_f_rdy);
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
    cyc("ill_decode", v_dec);
    repeat (3) cyc("ill_halt", mk(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd5,0,1));
    rst_n = 1'b0;
    cyc("ill_reset", 17'd0);
    rst_n = 1'b1;
    cyc("ill_recover", v_f_rdy);
`else
    cyc("ill_decode", mk(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd1,1,0));
    cyc("ill_next", v_f_rdy);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port opcode  input  7  instruction[6:0] from the instruction register.
REQ-004 SHALL have port funct3  input  3  instruction[14:12], used for branch sense.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current read/write this cycle.
REQ-007 SHALL have ports pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, pc_src, alu_src_a  output  1 each  datapath strobes/selects.
REQ-008 SHALL have ports alu_src_b  output  2  (00 reg, 01 const 4, 10 imm), alu_op  output  2  (00 add, 01 sub/compare, 10 funct-decoded).
REQ-009 SHALL have ports state  output  3  current state code; instr_done  output  1  retire pulse; halted  output  1  block in HALT.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH next cycle with all strobes 0.
REQ-011 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00; on mem_ready=1, ir_write=1 and pc_write=1 in the same cycle, next DECODE; else hold FETCH.
REQ-012 DECODE: SHALL register opcode and funct3 internally; supported opcodes 0110011, 0010011, 0000011, 0100011, 1100011 -> EXEC; any other -> behaviour per REQ-024.
REQ-013 EXEC R-type: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB; I-type: alu_src_b=10, alu_op=10 -> WB.
REQ-014 EXEC load/store: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM.
REQ-015 EXEC branch: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1; pc_write = zero XOR funct3[0] (BEQ/BNE); -> FETCH.
REQ-016 MEM load: mem_read=1 held until mem_ready, then -> WB; store: mem_write=1 held until mem_ready, then -> FETCH.
REQ-017 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 iff load -> FETCH.
REQ-018 instr_done SHALL pulse one cycle in the last state of each instruction (WB, store-MEM with mem_ready, branch EXEC).
REQ-019 Latency with mem_ready always 1: R/I 4 cycles, load 5, store 4, branch 3, measured FETCH entry to next FETCH entry.
REQ-020 mem_ready SHALL be ignored in DECODE, EXEC, WB, HALT; mem_read and mem_write SHALL never be 1 together.
REQ-021 All outputs SHALL be combinational from state, registered opcode/funct3, zero and mem_ready; no output glitches beyond those inputs.

Reset
REQ-022 While rst_n=0: state=FETCH, internal opcode/funct3 registers 0, every output 0 (including mem_read, state output reads 0), halted=0.
REQ-023 Reset asserted mid-instruction (any state, including pending MEM) SHALL abort immediately; first FETCH strobes appear the cycle after rst_n rises.

Configuration
REQ-024 Macro MULTICYCLE_ILLEGAL_HALT_EN: defined -> unsupported opcode in DECODE goes to HALT, halted=1, all strobes 0, exit only by reset; undefined -> unsupported opcode goes to FETCH as a NOP, instr_done=1 in that DECODE cycle, HALT unreachable and halted tied 0.

Verification
REQ-025 rst_n low 3 cycles, opcode=0110011, mem_ready=1 -> outputs 0 during reset; then state sequence 0,1,2,4,0; reg_write=1 only in cycle 4; instr_done once.
REQ-026 Load (0000011), mem_ready low 2 cycles in MEM -> mem_read held 3 MEM cycles, then WB with reg_write=1, mem_to_reg=1; 5+2=7 cycles total.
REQ-027 BEQ (1100011, funct3=000) with zero=1 -> pc_write=1, pc_src=1 in EXEC; with zero=0 -> pc_write=0; BNE (funct3=001) inverted.
REQ-028 Store (0100011), mem_ready=0 in FETCH 2 cycles -> FETCH held, ir_write only on ready cycle; MEM mem_write=1, reg_write never 1.
REQ-029 Opcode 1111111: macro defined -> state 5, halted=1 until reset; undefined -> state 0 next cycle, instr_done=1.
REQ-030 rst_n dropped during MEM with mem_write=1 -> mem_write falls same cycle, state=0, clean restart after release.
